// File: rtl/reg_dump_uart.sv
// Snapshots r0..r7 on snap and sends HEADER + 8 register bytes as 8N1 UART, LSB first.
// Define REG_DUMP_CHECKSUM_EN to append an XOR-of-registers checksum byte.
module reg_dump_uart #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       snap,
   input  logic [7:0] r0,
   input  logic [7:0] r1,
   input  logic [7:0] r2,
   input  logic [7:0] r3,
   input  logic [7:0] r4,
   input  logic [7:0] r5,
   input  logic [7:0] r6,
   input  logic [7:0] r7,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

   localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
`ifdef REG_DUMP_CHECKSUM_EN
   localparam logic [3:0]  LAST_BYTE  = 4'd9;
`else
   localparam logic [3:0]  LAST_BYTE  = 4'd8;
`endif

   state_t          state_q, state_d;
   logic [15:0]     timer_q, timer_d;
   logic [2:0]      bit_q,   bit_d;
   logic [3:0]      byte_q,  byte_d;
   logic [7:0][7:0] shot_q,  shot_d;
   logic            done_q,  done_d;
   logic [7:0]      cur_byte;

`ifdef REG_DUMP_CHECKSUM_EN
   logic [7:0] csum;

   always_comb begin
      csum = '0;
      for (int i = 0; i < 8; i++) begin
         csum = csum ^ shot_q[i];
      end
   end
`endif

   // Byte index 0 is the header, 1..8 map to the snapshot registers.
   always_comb begin
      cur_byte = HEADER;
      if (byte_q != 4'd0 && byte_q <= 4'd8) begin
         cur_byte = shot_q[3'(byte_q - 4'd1)];
      end
`ifdef REG_DUMP_CHECKSUM_EN
      if (byte_q == 4'd9) begin
         cur_byte = csum;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      shot_d  = shot_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (snap) begin
               shot_d  = {r7, r6, r5, r4, r3, r2, r1, r0};
               state_d = START;
               timer_d = BIT_RELOAD;
               bit_d   = 3'd0;
               byte_d  = 4'd0;
            end
         end
         START: begin
            if (timer_q == 16'd0) begin
               timer_d = BIT_RELOAD;
               bit_d   = 3'd0;
               state_d = DATA;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         DATA: begin
            if (timer_q == 16'd0) begin
               timer_d = BIT_RELOAD;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         STOP: begin
            if (timer_q == 16'd0) begin
               timer_d = BIT_RELOAD;
               state_d = NEXT;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // NEXT is resolved in the same cycle so consecutive bytes have no idle gap.
      if (state_d == NEXT) begin
         if (byte_q == LAST_BYTE) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            state_d = START;
            byte_d  = byte_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shot_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         shot_q  <= shot_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = cur_byte[bit_q];
         default: tx = 1'b1;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule
